gpr_writeback: RTL and testbench
================================

// Module: gpr_writeback
// PURPOSE
//  Write-side front end of the 8x16 general purpose register file (r0 reads zero, writes to r0 ignored).
//  Collects results from two producers, ALU and load/store unit (LSU), and serialises them onto the
//  file's single write port (write_en/write_dest/write_data). Keeps a per-register busy scoreboard so
//  issue logic can stall on a pending destination.
// PARAMETERS
//  DATA_W   16  result / register width
//  ADDR_W   3   register index width (NREG = 2**ADDR_W = 8)
//  LSU_DEPTH 4  LSU result FIFO entries (power of 2, >=2)
//  AGE_MAX  3   cycles a held ALU result may lose arbitration before it is forced through
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       asynchronous, active-high reset
//  issue_valid  in   1       decode issues an instruction that will write issue_dest
//  issue_dest   in   ADDR_W  destination of issued instruction
//  issue_ready  out  1       0 = issue_dest already busy; issuer must hold
//  alu_valid    in   1       ALU result offered
//  alu_ready    out  1       ALU holding register empty
//  alu_dest     in   ADDR_W  ALU destination
//  alu_data     in   DATA_W  ALU result
//  lsu_valid    in   1       load result offered
//  lsu_ready    out  1       LSU FIFO not full
//  lsu_dest     in   ADDR_W  load destination
//  lsu_data     in   DATA_W  load data
//  write_en     out  1       to register file write port
//  write_dest   out  ADDR_W  to register file
//  write_data   out  DATA_W  to register file
//  busy         out  2**ADDR_W  scoreboard; bit 0 always 0
//  err_unexp    out  1       sticky: result written to a register not marked busy
// BEHAVIOUR
//  Reset: write_en=0, write_dest=0, write_data=0, busy=0, err_unexp=0, FIFO empty, ALU hold empty, age=0.
//   Reset asserted mid-operation discards all pending results; no write is emitted after reset.
//  Handshakes: transfer when valid&&ready on a clock edge; ready never depends on same-cycle valid.
//   alu_ready = !hold_full || hold_selected_this_cycle. lsu_ready = fifo_count < LSU_DEPTH.
//  Dest 0: accepted normally, dropped at acceptance; never enters FIFO/hold, never uses the port.
//  Arbitration each cycle among FIFO head and ALU hold:
//   - only one present -> it wins; both -> LSU wins unless age == AGE_MAX, then ALU wins.
//   - age increments when hold is full and loses; clears when hold is written out or empty.
//  Output: winner registered onto write_en/dest/data; 1-cycle latency from selection, so an entry
//   accepted at edge N appears on the port at edge N+1 at the earliest (no same-cycle pass-through).
//   write_en=0 cycles hold write_dest/write_data at last value.
//  FIFO: circular, ADDR_W+DATA_W wide; pointers wrap at LSU_DEPTH; push and pop in same cycle when
//   full is legal only if the pop is selected (ready already low, so push cannot occur when full).
//  Scoreboard: busy[d] set at edge where issue_valid&&issue_ready&&d!=0.
//   issue_ready = (issue_dest==0) || !busy[issue_dest] (WAW stall).
//   busy[d] cleared at the edge where write_en is registered high for d. Set/clear of same d in one
//   edge cannot occur (issue blocked while busy); set of d and clear of e!=d both apply.
//  err_unexp set when a result is selected for a register with busy=0; cleared only by rst.
// STRUCTURE
//  Shared package gpr_pkg: DATA_W, ADDR_W, NREG, typedef wb_entry_t {dest, data}.
//  Sub-module gpr_wb_fifo (parameterised sync FIFO of wb_entry_t: push/pop/full/empty/count).
//  Arbiter, age counter, hold register and scoreboard stay in this module.
// TESTING
//  1 Reset: assert rst async mid-cycle with FIFO holding 2 entries -> all outputs 0, no later write_en.
//  2 Single ALU: issue r3, alu r3=16'hBEEF -> busy[3]=1; write_en at next edge r3=BEEF; busy[3]=0 after.
//  3 Collision: issue r1,r2; same cycle alu r1=0x1111, lsu r2=0x2222 -> r2 written first, r1 next cycle.
//  4 Starvation: hold ALU r4=0x0044 while LSU streams 6 loads to r5..r7 -> ALU written after exactly
//    AGE_MAX(3) losses, then LSU resumes.
//  5 FIFO full: 4 loads with port busy, 5th lsu_valid -> lsu_ready=0 until a pop; order preserved.
//  6 Edge cases: alu dest 0 -> no write_en, alu_ready stays 1; issue r6 twice -> issue_ready=0 on second
//    until r6 written; unissued write to r7 -> err_unexp=1 and stays 1.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types and widths for the general purpose register file write side.
package gpr_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int NREG    = 2 ** ADDR_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular FIFO of pending load results. The caller never pushes when full
// or pops when empty.
module gpr_wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [ENTRY_W-1:0]         push_data_i,
  input  logic                       pop_i,
  output logic [ENTRY_W-1:0]         pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
endmodule

// File: rtl/gpr_writeback.sv
// Serialises ALU and load results onto the register file write port and keeps
// the per-register busy scoreboard used by issue to stall on pending writes.
module gpr_writeback
  import gpr_pkg::*;
#(
  parameter int LSU_DEPTH = 4,
  parameter int AGE_MAX   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_dest,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_dest,
  output logic [DATA_W-1:0] write_data,
  output logic [NREG-1:0]   busy,
  output logic              err_unexp
);
  localparam int CNT_W = $clog2(LSU_DEPTH) + 1;
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  // Handshake: a transfer happens on a clock edge where valid && ready; every
  // ready is a function of registered state (and issue_dest), never of valid.

  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  wb_entry_t          fifo_head, hold_q, win;
  logic               hold_full_q;
  logic [AGE_W-1:0]   age_q;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               err_q, wen_q;
  logic [ADDR_W-1:0]  wdest_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               alu_sel, lsu_sel, sel_any;
  logic               alu_fire, alu_keep, issue_fire;

  gpr_wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({lsu_dest, lsu_data}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign fifo_head = fifo_rdata;

  // Loads win ties unless the held ALU result has already lost AGE_MAX times.
  always_comb begin
    alu_sel = 1'b0;
    lsu_sel = 1'b0;
    if (hold_full_q && (fifo_empty || age_q == AGE_W'(AGE_MAX))) alu_sel = 1'b1;
    else if (!fifo_empty)                                          lsu_sel = 1'b1;
  end

  assign sel_any = alu_sel | lsu_sel;
  assign win     = alu_sel ? hold_q : fifo_head;

  assign alu_ready   = !hold_full_q || alu_sel;
  assign lsu_ready   = (fifo_count < CNT_W'(LSU_DEPTH));
  assign issue_ready = (issue_dest == '0) || !busy_q[issue_dest];

  // Results for r0 complete their handshake but are discarded here.
  assign alu_fire   = alu_valid && alu_ready;
  assign alu_keep   = alu_fire && (alu_dest != '0);
  assign fifo_push  = lsu_valid && lsu_ready && (lsu_dest != '0) && !fifo_full;
  assign fifo_pop   = lsu_sel;
  assign issue_fire = issue_valid && issue_ready;

  always_comb begin
    busy_d = busy_q;
    if (sel_any) busy_d[win.dest] = 1'b0;
    if (issue_fire && issue_dest != '0) busy_d[issue_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      age_q       <= '0;
      busy_q      <= '0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      wdest_q     <= '0;
      wdata_q     <= '0;
    end else begin
      busy_q <= busy_d;
      wen_q  <= sel_any;
      if (sel_any) begin
        wdest_q <= win.dest;
        wdata_q <= win.data;
        if (!busy_q[win.dest]) err_q <= 1'b1;
      end
      if (alu_keep) begin
        hold_q.dest <= alu_dest;
        hold_q.data <= alu_data;
        hold_full_q <= 1'b1;
      end else if (alu_sel) begin
        hold_full_q <= 1'b0;
      end
      if (hold_full_q && lsu_sel) age_q <= age_q + 1'b1;
      else                        age_q <= '0;
    end
  end

  assign write_en   = wen_q;
  assign write_dest = wdest_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;
  assign err_unexp  = err_q;
endmodule

// File: tb/tb_gpr_writeback.sv
// Bench for gpr_writeback: directed scenarios plus random traffic against a
// queue-based reference model, with a scoreboard fed at arbitration time.
module tb_gpr_writeback;
  import gpr_pkg::*;

  localparam int EW        = ADDR_W + DATA_W;
  localparam int LSU_DEPTH = 4;
  localparam int AGE_MAX   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_dest = '0;
  logic              issue_ready;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              lsu_valid = 1'b0;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_dest = '0;
  logic [DATA_W-1:0] lsu_data = '0;
  logic              write_en;
  logic [ADDR_W-1:0] write_dest;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   busy;
  logic              err_unexp;

  always #5 clk = ~clk;

  gpr_writeback #(.LSU_DEPTH(LSU_DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .busy(busy), .err_unexp(err_unexp)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            obs_cyc[$];

  // Reference model: pending loads as a queue, one ALU slot, a loss count.
  logic [EW-1:0] m_fifo[$];
  bit            m_hold_v;
  logic [EW-1:0] m_hold;
  int            m_losses;
  logic [NREG-1:0] m_busy;
  bit            m_err, m_wrote;
  bit            acc_issue, acc_alu, acc_lsu;
  int            alu_acc_cyc, issue_acc_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int d, input int v);
    logic [EW-1:0] r;
    r = {d[ADDR_W-1:0], v[DATA_W-1:0]};
    return r;
  endfunction

  function automatic bit m_alu_wins();
    return m_hold_v && (m_fifo.size() == 0 || m_losses == AGE_MAX);
  endfunction
  function automatic bit m_alu_rdy();
    return !m_hold_v || m_alu_wins();
  endfunction
  function automatic bit m_lsu_rdy();
    return m_fifo.size() < LSU_DEPTH;
  endfunction
  function automatic bit m_issue_rdy();
    return issue_dest == 0 || !m_busy[issue_dest];
  endfunction

  task automatic model_step();
    bit aw, lw, ri, ra, rl;
    logic [EW-1:0] w;
    ri = m_issue_rdy(); ra = m_alu_rdy(); rl = m_lsu_rdy();
    aw = m_alu_wins();
    lw = !aw && m_fifo.size() != 0;
    acc_issue = issue_valid && ri;
    acc_alu   = alu_valid && ra;
    acc_lsu   = lsu_valid && rl;
    m_wrote   = aw || lw;
    if (m_wrote) begin
      w = aw ? m_hold : m_fifo[0];
      exp_q.push_back(w);
      if (!m_busy[w[EW-1:DATA_W]]) m_err = 1;
      m_busy[w[EW-1:DATA_W]] = 1'b0;
    end
    if (lw) begin
      void'(m_fifo.pop_front());
      m_losses = m_hold_v ? m_losses + 1 : 0;
    end else begin
      m_losses = 0;
    end
    if (aw) m_hold_v = 0;
    if (acc_alu && alu_dest != 0) begin m_hold = {alu_dest, alu_data}; m_hold_v = 1; end
    if (acc_lsu && lsu_dest != 0) m_fifo.push_back({lsu_dest, lsu_data});
    if (acc_issue && issue_dest != 0) m_busy[issue_dest] = 1'b1;
    if (acc_issue) issue_acc_cyc = cyc;
    if (acc_alu) alu_acc_cyc = cyc;
  endtask

  task automatic check_status();
    check("issue_ready", issue_ready, m_issue_rdy());
    check("alu_ready", alu_ready, m_alu_rdy());
    check("lsu_ready", lsu_ready, m_lsu_rdy());
    check("busy", busy, m_busy);
    check("err_unexp", err_unexp, m_err);
    check("write_en", write_en, m_wrote);
  endtask

  // One clock: check settled outputs, advance model at the edge, retire accepted offers.
  task automatic step();
    #1 check_status();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (acc_issue) issue_valid = 1'b0;
    if (acc_alu)   alu_valid   = 1'b0;
    if (acc_lsu)   lsu_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    exp_q.delete(); m_fifo.delete();
    m_hold_v = 0; m_losses = 0; m_busy = '0; m_err = 0; m_wrote = 0;
    acc_issue = 0; acc_alu = 0; acc_lsu = 0;
    #1;
    check("rst_write_en", write_en, 0);
    check("rst_write_dest", write_dest, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_unexp, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete(); obs_cyc.delete();
  endtask

  // Monitor: every port write is popped from the scoreboard and logged.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      obs_q.push_back({write_dest, write_data});
      obs_cyc.push_back(cyc - 1);
      if (exp_q.size() == 0) check("write_unexpected", {write_dest, write_data}, 32'hFFFF_FFFF);
      else check("write_entry", {write_dest, write_data}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int aseq, lseq, nxt;
    bit seen_full, reached;
    int pend[$];
    @(negedge clk);
    do_reset();

    // Single ALU result
    issue_valid = 1; issue_dest = 3; step();
    #1 check("t2_busy_set", busy[3], 1);
    alu_valid = 1; alu_dest = 3; alu_data = 16'hBEEF; step();
    idle(2); #2;
    check("t2_count", obs_q.size(), 1);
    check("t2_data", obs_q[0], ent(3, 'hBEEF));
    check("t2_latency", obs_cyc[0], alu_acc_cyc + 1);
    check("t2_busy_clr", busy[3], 0);

    // Collision: load first, ALU next cycle
    do_reset();
    issue_valid = 1; issue_dest = 1; step();
    issue_valid = 1; issue_dest = 2; step();
    alu_valid = 1; alu_dest = 1; alu_data = 16'h1111;
    lsu_valid = 1; lsu_dest = 2; lsu_data = 16'h2222; step();
    idle(3); #2;
    check("t3_count", obs_q.size(), 2);
    check("t3_first", obs_q[0], ent(2, 'h2222));
    check("t3_second", obs_q[1], ent(1, 'h1111));
    check("t3_cyc_first", obs_cyc[0], alu_acc_cyc + 1);
    check("t3_cyc_second", obs_cyc[1], alu_acc_cyc + 2);

    // Starvation: held ALU result forced through after AGE_MAX losses
    do_reset();
    for (int d = 4; d <= 7; d++) begin issue_valid = 1; issue_dest = d[ADDR_W-1:0]; step(); end
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1; lsu_dest = ADDR_W'(5 + i % 3); lsu_data = DATA_W'('h500 + i);
      if (i == 0) begin alu_valid = 1; alu_dest = 4; alu_data = 16'h0044; end
      step();
    end
    idle(5); #2;
    check("t4_count", obs_q.size(), 7);
    for (int k = 0; k < 7; k++) begin
      int li;
      li = (k < 3) ? k : k - 1;
      check($sformatf("t4_order%0d", k), obs_q[k], (k == 3) ? ent(4, 'h44) : ent(5 + li % 3, 'h500 + li));
    end
    check("t4_alu_cyc", obs_cyc[3], alu_acc_cyc + 1 + AGE_MAX);

    // FIFO fill: ALU keeps winning every AGE_MAX+1 cycles so loads accumulate
    do_reset();
    aseq = 0; lseq = 0; seen_full = 0;
    for (int c = 0; c < 40; c++) begin
      if (!alu_valid) begin alu_valid = 1; alu_dest = ADDR_W'(1 + c % 7); alu_data = DATA_W'('hB000 + aseq); aseq++; end
      if (!lsu_valid) begin lsu_valid = 1; lsu_dest = ADDR_W'(1 + lseq % 7); lsu_data = DATA_W'('hA000 + lseq); lseq++; end
      #1 if (lsu_ready === 1'b0) seen_full = 1;
      step();
    end
    check("t5_fifo_full_seen", seen_full, 1);
    idle(25); #2;
    nxt = 0;
    for (int k = 0; k < obs_q.size(); k++) begin
      if (obs_q[k][DATA_W-1:12] == 4'hA) begin
        check("t5_load_order", obs_q[k][DATA_W-1:0], DATA_W'('hA000 + nxt));
        nxt++;
      end
    end
    check("t5_load_count", nxt, lseq);

    // Reset mid-cycle with two loads pending
    do_reset();
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (!alu_valid) begin alu_valid = 1; alu_dest = ADDR_W'(1 + c % 7); alu_data = DATA_W'($urandom); end
      if (!lsu_valid) begin lsu_valid = 1; lsu_dest = ADDR_W'(1 + c % 7); lsu_data = DATA_W'($urandom); end
      step();
      if (m_fifo.size() == 2) reached = 1;
    end
    check("t1_fifo_two", reached, 1);
    do_reset();
    idle(5); #2;
    check("t1_no_write", obs_q.size(), 0);

    // Edge cases: r0 drop, WAW stall, unexpected write
    do_reset();
    alu_valid = 1; alu_dest = 0; alu_data = 16'h1234; step();
    #1 check("t6_alu_ready_r0", alu_ready, 1);
    idle(3); #2;
    check("t6_r0_no_write", obs_q.size(), 0);
    issue_valid = 1; issue_dest = 6; step();
    issue_valid = 1; issue_dest = 6;
    #1 check("t6_issue_stall", issue_ready, 0);
    alu_valid = 1; alu_dest = 6; alu_data = 16'h0606;
    for (int n = 0; n < 10 && issue_valid; n++) step();
    check("t6_issue_done", issue_valid, 0);
    check("t6_issue_cyc", issue_acc_cyc, alu_acc_cyc + 2);
    lsu_valid = 1; lsu_dest = 7; lsu_data = 16'h7777; step();
    idle(2);
    #1 check("t6_err_set", err_unexp, 1);
    idle(3);
    #1 check("t6_err_sticky", err_unexp, 1);
    check("t6_r7_write", obs_q[obs_q.size() - 1], ent(7, 'h7777));

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!issue_valid && $urandom_range(0, 2) == 0) begin
        issue_valid = 1; issue_dest = ADDR_W'($urandom_range(0, 7));
      end
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0) begin
          alu_valid = 1; alu_dest = 0; alu_data = DATA_W'($urandom);
        end else if (pend.size() > 0) begin
          alu_valid = 1; alu_dest = ADDR_W'(pend.pop_front()); alu_data = DATA_W'($urandom);
        end
      end
      if (!lsu_valid && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 7) == 0) begin
          lsu_valid = 1; lsu_dest = 0; lsu_data = DATA_W'($urandom);
        end else if (pend.size() > 0) begin
          lsu_valid = 1; lsu_dest = ADDR_W'(pend.pop_front()); lsu_data = DATA_W'($urandom);
        end
      end
      step();
      if (acc_issue && issue_dest != 0) pend.push_back(int'(issue_dest));
    end
    idle(20); #2;
    check("rand_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
